sum_result_reader: RTL and testbench

Reader-side buffer for the SimpleCPU adder. It captures each 3-bit `summation` result presented with a write strobe into a 10-entry circular history. It then returns the results in arrival order through a registered read port, so a downstream consumer (display/debug or a register-file writeback) can drain sums at its own pace. It also tracks occupancy and flags results lost to overflow.

---
 rtl/sum_result_reader.sv | 73 +++++++
 tb/tb_sum_result_reader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sum_result_reader.sv
// Reader-side history buffer for the adder's summation results: a DEPTH-entry
// circular store drained in arrival order through a registered read port.
module sum_result_reader #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             clear,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic             rd_acc, wr_acc, wr_drop, flush;

  // DEPTH is not a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    flush      = rst | clear;
    rd_acc     = rd_en & ~empty;
    // A same-cycle read frees the slot, so a full buffer still accepts.
    wr_acc     = wr_en & (~full | rd_acc);
    wr_drop    = wr_en & ~wr_acc;
    count_nxt  = count + CW'(wr_acc) - CW'(rd_acc);
    wr_ptr_nxt = wr_acc ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_nxt = rd_acc ? ptr_inc(rd_ptr) : rd_ptr;
  end

  // Storage is never reset; only the bookkeeping around it is.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      empty    <= (count_nxt == '0);
      full     <= (count_nxt == CW'(DEPTH));
      if (wr_drop) overflow <= 1'b1;
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_sum_result_reader.sv
// Bench for sum_result_reader: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_sum_result_reader;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, clear;
  logic [2:0] wr_data;
  logic [2:0] rd_data;
  logic       rd_valid, empty, full, overflow;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // reference model state
  int   q[$];
  int   m_rd_data  = 0;
  bit   m_rd_valid = 0;
  bit   m_ovf      = 0;

  sum_result_reader dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clear(clear), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || clear) begin
      q.delete();
      m_ovf = 0; m_rd_valid = 0; m_rd_data = 0;
    end else begin
      bit rdok, wrok;
      rdok = rd_en && q.size() > 0;
      wrok = wr_en && (q.size() < 10 || rdok);
      m_rd_valid = rdok;
      if (rdok) m_rd_data = q.pop_front();
      if (wrok) q.push_back(int'(wr_data));
      if (wr_en && !wrok) m_ovf = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rd_valid", int'(rd_valid), int'(m_rd_valid));
      if (m_rd_valid) chk("m_rd_data", int'(rd_data), m_rd_data);
      chk("m_count", int'(count), q.size());
      chk("m_empty", int'(empty), int'(q.size() == 0));
      chk("m_full", int'(full), int'(q.size() == 10));
      chk("m_overflow", int'(overflow), int'(m_ovf));
    end
  end

  // Drive at a falling edge, return at the next falling edge.
  task automatic step(input bit w, input int d, input bit r,
                      input bit c = 0, input bit rs = 0);
    wr_en = w; wr_data = 3'(d); rd_en = r; clear = c; rst = rs;
    @(negedge clk);
    wr_en = 0; rd_en = 0; clear = 0; rst = 0;
  endtask

  int vals[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 2, 5};
  int seq3[3]  = '{3, 1, 6};

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; clear = 0; wr_data = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_en = 1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      chk("idle_rd_valid", int'(rd_valid), 0);
    end

    // in-order drain
    foreach (seq3[i]) step(1, seq3[i], 0);
    chk("drain3_count", int'(count), 3);
    foreach (seq3[i]) begin
      step(0, 0, 1);
      chk("drain3_valid", int'(rd_valid), 1);
      chk("drain3_data", int'(rd_data), seq3[i]);
    end
    step(0, 0, 0);
    chk("drain3_valid_end", int'(rd_valid), 0);
    chk("drain3_empty", int'(empty), 1);

    // fill and overflow
    foreach (vals[i]) step(1, vals[i], 0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 10);
    step(1, 4, 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 10);
    foreach (vals[i]) begin
      step(0, 0, 1);
      chk("ovf_drain", int'(rd_data), vals[i]);
    end
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_drained_empty", int'(empty), 1);
    step(0, 0, 0, 1);
    chk("clear_ovf", int'(overflow), 0);

    // wrap-around: 25 write/read pairs
    for (int i = 0; i < 25; i++) begin
      int v;
      v = int'($urandom_range(0, 7));
      step(1, v, 0);
      chk("wrap_count1", int'(count), 1);
      step(0, 0, 1);
      chk("wrap_data", int'(rd_data), v);
      chk("wrap_count0", int'(count), 0);
    end

    // simultaneous read+write on empty
    step(1, 5, 1);
    chk("simE_count", int'(count), 1);
    chk("simE_valid", int'(rd_valid), 0);
    step(0, 0, 1);
    chk("simE_data", int'(rd_data), 5);
    // simultaneous read+write on full
    foreach (vals[i]) step(1, vals[i], 0);
    step(1, 7, 1);
    chk("simF_valid", int'(rd_valid), 1);
    chk("simF_data", int'(rd_data), 0);
    chk("simF_count", int'(count), 10);
    chk("simF_ovf", int'(overflow), 0);
    for (int i = 1; i < 10; i++) begin
      step(0, 0, 1);
      chk("simF_drain", int'(rd_data), vals[i]);
    end
    step(0, 0, 1);
    chk("simF_last", int'(rd_data), 7);
    chk("simF_empty", int'(empty), 1);

    // mid-operation flush
    for (int i = 0; i < 4; i++) step(1, i + 1, 0);
    step(0, 0, 1);
    step(1, 3, 1, 1);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_valid", int'(rd_valid), 0);
    chk("flush_ovf", int'(overflow), 0);
    step(1, 2, 0);
    step(0, 0, 1);
    chk("flush_rb", int'(rd_data), 2);

    // random traffic, write-heavy and read-heavy phases
    for (int i = 0; i < 1500; i++) begin
      int wp;
      wp = (i / 150) % 2 == 0 ? 75 : 35;
      step(int'($urandom_range(0, 99)) < wp, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 99)) < (100 - wp),
           $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
